rr_write_arbiter: RTL

//   Round-robin arbiter that shares one W-bit register-write datapath between N requesters.

---
 rtl/rr_write_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_write_arbiter.sv
// rr_write_arbiter
//   Shares one W-bit register-write port between N requesters. One requester
//   is granted at a time for a burst of beats. Its data is muxed onto the
//   shared port, and priority rotates to the next requester after each burst.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; pick the next requester round-robin from ptr
//   GRANT | one requester owns the port until last / HOLD_MAX / withdraw
//
// Ports
//   i_clk    clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_req    per-requester request, held high while beats remain
//   i_last   per-requester last-beat flag, used only with an accepted beat
//   i_data   per-requester beat data, requester k at [k*W +: W]
//   i_ready  downstream accepts a beat this cycle
//   o_gnt    registered one-hot grant
//   o_valid  shared port carries a valid beat
//   o_data   shared port data (zero when not valid)
//   o_busy   high while in GRANT
module rr_write_arbiter #(
    parameter int N        = 4,
    parameter int W        = 10,
    parameter int HOLD_MAX = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_last,
    input  logic [N*W-1:0] i_data,
    input  logic           i_ready,
    output logic [N-1:0]   o_gnt,
    output logic           o_valid,
    output logic [W-1:0]   o_data,
    output logic           o_busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic            grantee_req;
    logic            grantee_last;
    logic [W-1:0]    data_mux;
    logic            release_c;

    // The grant is one-hot, so masking and OR-reducing selects the grantee's bits.
    assign grantee_req  = |(i_req & gnt_q);
    assign grantee_last = |(i_last & gnt_q);

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q[k]) gnt_idx = PW'(k);
        end
    end

    always_comb begin
        data_mux = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q[k] && i_req[k]) data_mux = i_data[k*W +: W];
        end
    end

    // Search ptr, ptr+1, ... wrapping at N; the first set request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found && i_req[(int'(ptr_q) + i) % N]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        release_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d   = N'(1) << pick_idx;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!grantee_req) begin
                    release_c = 1'b1;
                end else if (i_ready) begin
                    if (grantee_last || (cnt_q == CW'(HOLD_MAX - 1))) begin
                        release_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (release_c) begin
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_valid = grantee_req;
    assign o_data  = data_mux;
    assign o_busy  = (state_q == S_GRANT);

endmodule
